// File: rtl/hv_pair_streamer.sv
// Streams two hypervectors from a synchronous-read store, interleaved A[i], B[i], to the similarity engine.
// Optional `HV_STREAM_ABORT_EN adds an abort input and an aborted pulse output.
module hv_pair_streamer #(
   parameter int HV_DATA_WIDTH = 32,
   parameter int HV_LENGTH     = 1024,
   parameter int ADDR_WIDTH    = 10
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [ADDR_WIDTH-1:0]    a_base,
   input  logic [ADDR_WIDTH-1:0]    b_base,
   output logic                     mem_rd,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   input  logic [HV_DATA_WIDTH-1:0] mem_data,
   output logic                     valid,
   output logic                     first,
   output logic                     last,
   output logic [HV_DATA_WIDTH-1:0] data_out,
   input  logic                     ready,
   input  logic                     done_in,
`ifdef HV_STREAM_ABORT_EN
   input  logic                     abort,
   output logic                     aborted,
`endif
   output logic                     busy,
   output logic                     done
);

   localparam int CW = (HV_LENGTH > 1) ? $clog2(HV_LENGTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH_A = 3'd1,
      S_LOAD_A  = 3'd2,
      S_SEND_A  = 3'd3,
      S_FETCH_B = 3'd4,
      S_LOAD_B  = 3'd5,
      S_SEND_B  = 3'd6,
      S_DRAIN   = 3'd7
   } state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             i_q, i_d;
   logic [ADDR_WIDTH-1:0]     a_base_q, a_base_d, b_base_q, b_base_d;
   logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
   logic [HV_DATA_WIDTH-1:0]  data_out_q, data_out_d;
   logic                      mem_rd_q, mem_rd_d;
   logic                      valid_q, valid_d, first_q, first_d, last_q, last_d;
   logic                      busy_q, busy_d, done_q, done_d;
   logic                      xfer_s, abort_s;

   assign xfer_s = valid_q && ready;

`ifdef HV_STREAM_ABORT_EN
   logic aborted_q, aborted_d;
   assign abort_s = abort && (state_q != S_IDLE);
   assign aborted = aborted_q;
`else
   assign abort_s = 1'b0;
`endif

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         i_q        <= {CW{1'b0}};
         a_base_q   <= {ADDR_WIDTH{1'b0}};
         b_base_q   <= {ADDR_WIDTH{1'b0}};
         mem_addr_q <= {ADDR_WIDTH{1'b0}};
         data_out_q <= {HV_DATA_WIDTH{1'b0}};
         mem_rd_q   <= 1'b0;
         valid_q    <= 1'b0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef HV_STREAM_ABORT_EN
         aborted_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         a_base_q   <= a_base_d;
         b_base_q   <= b_base_d;
         mem_addr_q <= mem_addr_d;
         data_out_q <= data_out_d;
         mem_rd_q   <= mem_rd_d;
         valid_q    <= valid_d;
         first_q    <= first_d;
         last_q     <= last_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef HV_STREAM_ABORT_EN
         aborted_q  <= aborted_d;
`endif
      end
   end

   // Next-state logic; a start coinciding with the done pulse is not accepted
   always_comb begin
      state_d = state_q;
      if (abort_s) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    if (start && !done_q) state_d = S_FETCH_A; else state_d = S_IDLE;
            S_FETCH_A: state_d = S_LOAD_A;
            S_LOAD_A:  state_d = S_SEND_A;
            S_SEND_A:  if (xfer_s) state_d = S_FETCH_B; else state_d = S_SEND_A;
            S_FETCH_B: state_d = S_LOAD_B;
            S_LOAD_B:  state_d = S_SEND_B;
            S_SEND_B: begin
               if (xfer_s) begin
                  if (last_q) state_d = S_DRAIN; else state_d = S_FETCH_A;
               end else begin
                  state_d = S_SEND_B;
               end
            end
            S_DRAIN:   if (done_in) state_d = S_IDLE; else state_d = S_DRAIN;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // Output/datapath next values; the read strobe is derived from the next state so it is registered in FETCH
   always_comb begin
      i_d        = i_q;
      a_base_d   = a_base_q;
      b_base_d   = b_base_q;
      data_out_d = data_out_q;
      valid_d    = valid_q;
      first_d    = first_q;
      last_d     = last_q;
      done_d     = 1'b0;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;
`ifdef HV_STREAM_ABORT_EN
      aborted_d  = abort_s;
`endif
      case (state_q)
         S_IDLE: begin
            if (start && !done_q) begin
               a_base_d = a_base;
               b_base_d = b_base;
               i_d      = {CW{1'b0}};
            end else begin
               i_d = i_q;
            end
         end
         S_LOAD_A: begin
            data_out_d = mem_data;
            first_d    = (i_q == {CW{1'b0}});
            last_d     = 1'b0;
            valid_d    = 1'b1;
         end
         S_LOAD_B: begin
            data_out_d = mem_data;
            first_d    = 1'b0;
            last_d     = (i_q == CW'(HV_LENGTH - 1));
            valid_d    = 1'b1;
         end
         S_SEND_A, S_SEND_B: begin
            if (xfer_s) begin
               valid_d = 1'b0;
               first_d = 1'b0;
               last_d  = 1'b0;
               if (state_q == S_SEND_B && !last_q) i_d = i_q + CW'(1); else i_d = i_q;
            end else begin
               valid_d = valid_q;
            end
         end
         S_DRAIN: if (done_in) done_d = 1'b1; else done_d = 1'b0;
         default: done_d = 1'b0;
      endcase
      case (state_d)
         S_FETCH_A: begin
            mem_rd_d   = 1'b1;
            mem_addr_d = a_base_d + ADDR_WIDTH'(i_d);
         end
         S_FETCH_B: begin
            mem_rd_d   = 1'b1;
            mem_addr_d = b_base_d + ADDR_WIDTH'(i_d);
         end
         default: mem_rd_d = 1'b0;
      endcase
      if (abort_s) begin
         valid_d = 1'b0;
         first_d = 1'b0;
         last_d  = 1'b0;
         done_d  = 1'b0;
      end else begin
         done_d = done_d;
      end
      busy_d = (state_d != S_IDLE);
   end

   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign valid    = valid_q;
   assign first    = first_q;
   assign last     = last_q;
   assign data_out = data_out_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_hv_pair_streamer.sv
// Randomized bench for hv_pair_streamer: two instances (HV_LENGTH 4 and 1) against a queue-based stream model.
// Exercises abort behaviour only when `HV_STREAM_ABORT_EN is defined.
module tb_hv_pair_streamer;
   localparam int DW = 32;
   localparam int AW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n [2];
   logic          start [2];
   logic [AW-1:0] a_base [2];
   logic [AW-1:0] b_base [2];
   logic          mem_rd [2];
   logic [AW-1:0] mem_addr [2];
   logic [DW-1:0] mem_data [2];
   logic          valid [2];
   logic          first [2];
   logic          last [2];
   logic [DW-1:0] data_out [2];
   logic          ready [2];
   logic          done_in [2];
   logic          busy [2];
   logic          done [2];
`ifdef HV_STREAM_ABORT_EN
   logic          abort [2];
   logic          aborted [2];
`endif

   logic [DW-1:0] mem [2][1024];
   int n_vec = 0;
   int n_err = 0;

   hv_pair_streamer #(.HV_DATA_WIDTH(DW), .HV_LENGTH(4), .ADDR_WIDTH(AW)) u_dut4 (
      .clk(clk), .reset_n(reset_n[0]), .start(start[0]), .a_base(a_base[0]), .b_base(b_base[0]),
      .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]), .valid(valid[0]),
      .first(first[0]), .last(last[0]), .data_out(data_out[0]), .ready(ready[0]), .done_in(done_in[0]),
`ifdef HV_STREAM_ABORT_EN
      .abort(abort[0]), .aborted(aborted[0]),
`endif
      .busy(busy[0]), .done(done[0]));

   hv_pair_streamer #(.HV_DATA_WIDTH(DW), .HV_LENGTH(1), .ADDR_WIDTH(AW)) u_dut1 (
      .clk(clk), .reset_n(reset_n[1]), .start(start[1]), .a_base(a_base[1]), .b_base(b_base[1]),
      .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]), .valid(valid[1]),
      .first(first[1]), .last(last[1]), .data_out(data_out[1]), .ready(ready[1]), .done_in(done_in[1]),
`ifdef HV_STREAM_ABORT_EN
      .abort(abort[1]), .aborted(aborted[1]),
`endif
      .busy(busy[1]), .done(done[1]));

   // Synchronous-read memory; garbage on the bus whenever no read was issued
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         mem_data[d] <= mem_rd[d] ? mem[d][mem_addr[d]] : $urandom;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input int d, input string tag);
      chk({tag, "_outs"}, {valid[d], first[d], last[d], mem_rd[d], busy[d], done[d]}, 64'd0);
      chk({tag, "_data"}, data_out[d], 64'd0);
      chk({tag, "_addr"}, mem_addr[d], 64'd0);
   endtask

   task automatic idle_inputs(input int d);
      start[d] = 1'b0; ready[d] = 1'b1; done_in[d] = 1'b0;
`ifdef HV_STREAM_ABORT_EN
      abort[d] = 1'b0;
`endif
   endtask

   // One transfer: builds the expected word/address order from the element-interleaving rule
   task automatic run_stream(input int d, input int len, input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                             input bit rnd, input int stall_word, input int rst_word,
                             input int abort_elem, input int drain_dly);
      logic [DW+1:0] exp_w [$];
      logic [AW-1:0] exp_a [$];
      logic [DW+1:0] held, e;
      logic [AW-1:0] aa, ba;
      bit holding, finished;
      int widx, gap, cyc, stall_cnt;
      for (int i = 0; i < len; i++) begin
         aa = ab + AW'(i);
         ba = bb + AW'(i);
         exp_a.push_back(aa);
         exp_a.push_back(ba);
         exp_w.push_back({(i == 0), 1'b0, mem[d][aa]});
         exp_w.push_back({1'b0, (i == len - 1), mem[d][ba]});
      end
      @(negedge clk);
      start[d] = 1'b1; a_base[d] = ab; b_base[d] = bb; ready[d] = 1'b1; done_in[d] = 1'b1;
      @(posedge clk);
      #1;
      start[d] = 1'b0; a_base[d] = AW'($urandom); b_base[d] = AW'($urandom);
      holding = 1'b0; finished = 1'b0; held = '0;
      widx = 0; gap = 0; cyc = 0; stall_cnt = 0;
      while (!finished && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         done_in[d] = 1'($urandom_range(0, 1));
         start[d] = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
         chk("busy", busy[d], 64'd1);
         chk("done_early", done[d], 64'd0);
         if (cyc == 1) chk("rd_latency", mem_rd[d], 64'd1);
         if (cyc == 3) chk("valid_latency", valid[d], 64'd1);
`ifdef HV_STREAM_ABORT_EN
         if (mem_rd[d] && abort_elem >= 0 && exp_a.size() == 2 * (len - abort_elem)) begin
            abort[d] = 1'b1; start[d] = 1'b0; done_in[d] = 1'b1;
            @(negedge clk);
            chk("abort_pulse", aborted[d], 64'd1);
            chk("abort_outs", {valid[d], first[d], last[d], mem_rd[d], busy[d], done[d]}, 64'd0);
            abort[d] = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk("abort_once", {aborted[d], done[d], busy[d]}, 64'd0);
            end
            idle_inputs(d);
            return;
         end
`endif
         if (mem_rd[d]) begin
            if (exp_a.size() == 0) chk("extra_read", 64'd1, 64'd0);
            else chk("rd_addr", mem_addr[d], exp_a.pop_front());
         end
         if (valid[d]) begin
            if (gap > 0) chk("valid_gap", gap, 64'd2);
            gap = 0;
            if (holding) chk("hold_stable", {first[d], last[d], data_out[d]}, held);
            if (widx == rst_word) begin
               reset_n[d] = 1'b0;
               @(negedge clk);
               chk_all_zero(d, "reset_abort");
               reset_n[d] = 1'b1;
               idle_inputs(d);
               return;
            end
            if (widx == stall_word && stall_cnt < 5) begin
               ready[d] = 1'b0;
               stall_cnt++;
            end else begin
               ready[d] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (ready[d]) begin
               e = exp_w.pop_front();
               chk("word", {first[d], last[d], data_out[d]}, e);
               widx++;
               holding = 1'b0;
               if (exp_w.size() == 0) begin
                  finished = 1'b1;
                  done_in[d] = 1'b0;
                  start[d] = 1'b0;
               end
            end else begin
               holding = 1'b1;
               held = {first[d], last[d], data_out[d]};
            end
         end else begin
            if (holding) chk("valid_hold", valid[d], 64'd1);
            if (widx > 0) gap++;
            ready[d] = 1'($urandom_range(0, 1));
         end
      end
      if (!finished) begin
         chk("stream_timeout", 64'd0, 64'd1);
         idle_inputs(d);
         return;
      end
      chk("reads_done", exp_a.size(), 64'd0);
      for (int k = 0; k < drain_dly; k++) begin
         @(negedge clk);
         chk("drain_wait", {busy[d], done[d], valid[d]}, 64'b100);
      end
      done_in[d] = 1'b1;
      @(negedge clk);
      chk("done_rise", done[d], 64'd1);
      chk("busy_fall", busy[d], 64'd0);
      start[d] = 1'b1;
      @(negedge clk);
      chk("done_pulse", done[d], 64'd0);
      chk("start_at_done", {busy[d], mem_rd[d]}, 64'd0);
      idle_inputs(d);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         reset_n[d] = 1'b0; a_base[d] = '0; b_base[d] = '0;
         idle_inputs(d);
         for (int k = 0; k < 1024; k++) mem[d][k] = $urandom;
      end
      mem[0][0] = 32'h3F800000; mem[0][1] = 32'h40000000;
      mem[0][2] = 32'h40400000; mem[0][3] = 32'h40800000;
      mem[0][256] = 32'h40A00000; mem[0][257] = 32'h40C00000;
      mem[0][258] = 32'h40E00000; mem[0][259] = 32'h41000000;
      repeat (3) @(negedge clk);
      chk_all_zero(0, "reset4");
      chk_all_zero(1, "reset1");
      reset_n[0] = 1'b1; reset_n[1] = 1'b1;
      repeat (2) @(negedge clk);

      run_stream(0, 4, 10'h000, 10'h100, 1'b0, -1, -1, -1, 20);
      run_stream(0, 4, 10'h000, 10'h100, 1'b0, 3, -1, -1, 4);
      run_stream(0, 4, 10'h3FE, 10'h200, 1'b0, -1, -1, -1, 2);
      run_stream(1, 1, 10'h005, 10'h105, 1'b0, -1, -1, -1, 3);
      run_stream(0, 4, 10'h000, 10'h100, 1'b0, -1, 5, -1, 1);
      run_stream(0, 4, 10'h000, 10'h100, 1'b0, -1, -1, -1, 1);
`ifdef HV_STREAM_ABORT_EN
      run_stream(0, 4, 10'h000, 10'h100, 1'b0, -1, -1, 1, 1);
      run_stream(0, 4, 10'h000, 10'h100, 1'b0, -1, -1, -1, 1);
`endif
      for (int r = 0; r < 8; r++) begin
         run_stream(r % 2, (r % 2 == 0) ? 4 : 1, AW'($urandom), AW'($urandom), 1'b1, -1, -1, -1,
                    $urandom_range(1, 10));
      end
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
